mips32_pipe: RTL and testbench



---
 rtl/mips32_pkg.sv | 50 +++++
 rtl/mips32_pipe_alu.sv | 24 ++
 rtl/mips32_pipe.sv | 165 ++++++++++++++++
 tb/tb_mips32_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared encodings for the mips32_pipe core: opcodes, instruction classes and
// the bubble word that fills flushed or stalled pipeline slots.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Opcode 011111 is unassigned, so this word decodes as a NOP.
  localparam logic [5:0]  NOP_OP   = 6'b011111;
  localparam logic [31:0] NOP_WORD = {NOP_OP, 26'd0};

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } itype_t;

  function automatic itype_t decode(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  function automatic logic writes_reg(input itype_t t);
    return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
  endfunction

endpackage

// File: rtl/mips32_pipe_alu.sv
// Combinational ALU. The raw opcode selects the operation; loads, stores and
// unassigned opcodes fall through to an add (address computation).
module mips32_pipe_alu
  import mips32_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      OP_SUB, OP_SUBI: y = a - b;
      OP_AND:          y = a & b;
      OP_OR:           y = a | b;
      OP_SLT, OP_SLTI: y = {31'd0, ($signed(a) < $signed(b))};
      OP_MUL:          y = a * b;
      default:         y = a + b;
    endcase
  end

endmodule

// File: rtl/mips32_pipe.sv
// Five-stage in-order MIPS32-subset core with unified memory, EX-stage branch
// resolution, ALU/load forwarding into EX and write-through register bypass.
module mips32_pipe
  import mips32_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];

  logic [31:0] if_id_ir, if_id_npc;

  logic [5:0]  id_ex_op;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst;
  itype_t      id_ex_type;
  logic [31:0] id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;

  itype_t      ex_mem_type;
  logic [4:0]  ex_mem_dst;
  logic [31:0] ex_mem_alu, ex_mem_b;

  itype_t      mem_wb_type;
  logic [4:0]  mem_wb_dst;
  logic [31:0] mem_wb_alu, mem_wb_lmd;

  assign halted = HALTED;

  // Writeback
  logic        wb_we;
  logic [31:0] wb_val;
  assign wb_we  = writes_reg(mem_wb_type) && (mem_wb_dst != 5'd0) && !HALTED;
  assign wb_val = (mem_wb_type == LOAD) ? mem_wb_lmd : mem_wb_alu;

  // Decode
  logic [4:0]  id_rs, id_rt, id_dst;
  itype_t      id_type;
  logic [31:0] id_a, id_b, id_imm;
  assign id_rs   = if_id_ir[25:21];
  assign id_rt   = if_id_ir[20:16];
  assign id_type = decode(if_id_ir[31:26]);
  assign id_dst  = (id_type == RR_ALU) ? if_id_ir[15:11] : if_id_ir[20:16];
  assign id_imm  = {{16{if_id_ir[15]}}, if_id_ir[15:0]};

  always_comb begin
    id_a = Reg[id_rs];
    id_b = Reg[id_rt];
    if (id_rs == 5'd0)                        id_a = '0;
    else if (wb_we && (mem_wb_dst == id_rs))  id_a = wb_val;
    if (id_rt == 5'd0)                        id_b = '0;
    else if (wb_we && (mem_wb_dst == id_rt))  id_b = wb_val;
  end

  // Execute: a load sitting in EX/MEM has no data yet, so it never forwards.
  logic        em_fwd;
  logic [31:0] ex_a, ex_b, alu_b, alu_y, br_target;
  logic        br_taken, stall_if;
  assign em_fwd = ((ex_mem_type == RR_ALU) || (ex_mem_type == RM_ALU)) && (ex_mem_dst != 5'd0);

  always_comb begin
    ex_a = id_ex_a;
    ex_b = id_ex_b;
    if (em_fwd && (ex_mem_dst == id_ex_rs))      ex_a = ex_mem_alu;
    else if (wb_we && (mem_wb_dst == id_ex_rs))  ex_a = wb_val;
    if (em_fwd && (ex_mem_dst == id_ex_rt))      ex_b = ex_mem_alu;
    else if (wb_we && (mem_wb_dst == id_ex_rt))  ex_b = wb_val;
  end

  assign alu_b     = (id_ex_type == RR_ALU) ? ex_b : id_ex_imm;
  assign br_target = id_ex_npc + id_ex_imm;
  assign br_taken  = (id_ex_type == BRANCH) &&
                     (((id_ex_op == OP_BEQZ)  && (ex_a == 32'd0)) ||
                      ((id_ex_op == OP_BNEQZ) && (ex_a != 32'd0)));

  // Fetch stays frozen from the moment HLT is decoded until reset.
  assign stall_if = HALTED || (id_type == HALT) || (id_ex_type == HALT) ||
                    (ex_mem_type == HALT) || (mem_wb_type == HALT);

  mips32_pipe_alu u_alu (
    .op (id_ex_op),
    .a  (ex_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      if_id_ir     <= NOP_WORD;
      if_id_npc    <= '0;
      id_ex_op     <= NOP_OP;
      id_ex_rs     <= '0;
      id_ex_rt     <= '0;
      id_ex_dst    <= '0;
      id_ex_type   <= NOP;
      id_ex_npc    <= '0;
      id_ex_a      <= '0;
      id_ex_b      <= '0;
      id_ex_imm    <= '0;
      ex_mem_type  <= NOP;
      ex_mem_dst   <= '0;
      ex_mem_alu   <= '0;
      ex_mem_b     <= '0;
      mem_wb_type  <= NOP;
      mem_wb_dst   <= '0;
      mem_wb_alu   <= '0;
      mem_wb_lmd   <= '0;
    end else begin
      HALTED       <= HALTED | (mem_wb_type == HALT);
      TAKEN_BRANCH <= br_taken;

      if (!HALTED) begin
        if (br_taken)       PC <= br_target;
        else if (!stall_if) PC <= PC + 32'd1;
      end

      if_id_npc <= PC + 32'd1;
      if (br_taken || stall_if) if_id_ir <= NOP_WORD;
      else                      if_id_ir <= Mem[PC[AW-1:0]];

      id_ex_rs  <= id_rs;
      id_ex_rt  <= id_rt;
      id_ex_dst <= id_dst;
      id_ex_npc <= if_id_npc;
      id_ex_a   <= id_a;
      id_ex_b   <= id_b;
      id_ex_imm <= id_imm;
      if (br_taken) begin
        id_ex_op   <= NOP_OP;
        id_ex_type <= NOP;
      end else begin
        id_ex_op   <= if_id_ir[31:26];
        id_ex_type <= id_type;
      end

      ex_mem_type <= id_ex_type;
      ex_mem_dst  <= id_ex_dst;
      ex_mem_alu  <= alu_y;
      ex_mem_b    <= ex_b;

      mem_wb_type <= ex_mem_type;
      mem_wb_dst  <= ex_mem_dst;
      mem_wb_alu  <= ex_mem_alu;
      mem_wb_lmd  <= Mem[ex_mem_alu[AW-1:0]];
    end
  end

  // Architectural storage is deliberately left out of reset.
  always_ff @(posedge clk1) begin
    if (wb_we) Reg[mem_wb_dst] <= wb_val;
    if ((ex_mem_type == STORE) && !HALTED) Mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
  end

endmodule

// File: tb/tb_mips32_pipe.sv
// Directed-program bench for mips32_pipe: preloads memory/registers, runs each
// program to halt and compares architectural state with hand-computed values.
module tb_mips32_pipe;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic clk1  = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  int n_vec     = 0;
  int n_err     = 0;
  int taken_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hlt_w;

  mips32_pipe dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .halted (halted)
  );

  // Clock / reset
  always #5 clk1 = ~clk1;

  always @(negedge clk1) if (rst_n && dut.TAKEN_BRANCH) taken_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [31:0] d, s, t;
    d = rd; s = rs; t = rt;
    return {op, s[4:0], t[4:0], d[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [31:0] s, t, i;
    s = rs; t = rt; i = imm;
    return {op, s[4:0], t[4:0], i[15:0]};
  endfunction

  // Driver tasks
  task automatic prep();
    @(negedge clk1);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
  endtask

  task automatic run(input string tag, input int budget);
    int cyc;
    cyc = 0;
    @(negedge clk1);
    taken_cnt = 0;
    rst_n = 1'b1;
    while (!halted && cyc < budget) begin
      @(negedge clk1);
      cyc++;
    end
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    hlt_w = {OP_HLT, 26'd0};

    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // ALU chain with every forwarding distance
    prep();
    dut.Mem[0] = ri(OP_ADDI, 1, 0, 10);
    dut.Mem[1] = ri(OP_ADDI, 2, 0, 20);
    dut.Mem[2] = ri(OP_ADDI, 3, 0, 25);
    dut.Mem[3] = rr(OP_ADD, 4, 1, 2);
    dut.Mem[4] = rr(OP_ADD, 5, 4, 3);
    dut.Mem[5] = hlt_w;
    run("alu", 200);
    exp_q = {32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
    for (int r = 1; r <= 5; r++) check($sformatf("alu_r%0d", r), dut.Reg[r], exp_q.pop_front());
    check("alu_pc", dut.PC, 32'd6);
    check("alu_r0", dut.Reg[0], 32'd0);

    // Load / store
    prep();
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = ri(OP_ADDI, 1, 0, 120);
    dut.Mem[1] = ri(OP_LW, 2, 1, 0);
    dut.Mem[2] = rr(OP_OR, 3, 3, 3);
    dut.Mem[3] = ri(OP_ADDI, 2, 2, 45);
    dut.Mem[4] = ri(OP_SW, 2, 1, 1);
    dut.Mem[5] = hlt_w;
    run("ldst", 200);
    check("ldst_mem121", dut.Mem[121], 32'd130);
    check("ldst_r2", dut.Reg[2], 32'd130);
    check("ldst_r3", dut.Reg[3], 32'd3);

    // Load-use without interlock, forwarding priority, remaining ALU ops
    prep();
    dut.Mem[50] = 32'd77;
    dut.Mem[0]  = ri(OP_LW, 6, 0, 50);
    dut.Mem[1]  = rr(OP_ADD, 7, 6, 0);
    dut.Mem[2]  = rr(OP_ADD, 8, 6, 0);
    dut.Mem[3]  = ri(OP_ADDI, 13, 0, 1);
    dut.Mem[4]  = ri(OP_ADDI, 13, 0, 2);
    dut.Mem[5]  = rr(OP_ADD, 14, 13, 13);
    dut.Mem[6]  = rr(OP_SUB, 15, 0, 13);
    dut.Mem[7]  = rr(OP_SLT, 16, 15, 13);
    dut.Mem[8]  = ri(OP_SLTI, 17, 13, -5);
    dut.Mem[9]  = rr(OP_AND, 18, 14, 15);
    dut.Mem[10] = ri(OP_SUBI, 19, 14, 10);
    dut.Mem[11] = hlt_w;
    run("mix", 200);
    check("mix_r6_load", dut.Reg[6], 32'd77);
    check("mix_r7_stale", dut.Reg[7], 32'd6);
    check("mix_r8_fwd", dut.Reg[8], 32'd77);
    check("mix_r14_prio", dut.Reg[14], 32'd4);
    check("mix_r15_sub", dut.Reg[15], 32'hFFFF_FFFE);
    check("mix_r16_slt", dut.Reg[16], 32'd1);
    check("mix_r17_slti", dut.Reg[17], 32'd0);
    check("mix_r18_and", dut.Reg[18], 32'd4);
    check("mix_r19_subi", dut.Reg[19], 32'hFFFF_FFFA);

    // Factorial loop
    prep();
    dut.Mem[200] = 32'd7;
    dut.Mem[0] = ri(OP_ADDI, 10, 0, 200);
    dut.Mem[1] = ri(OP_ADDI, 2, 0, 1);
    dut.Mem[2] = ri(OP_LW, 3, 10, 0);
    dut.Mem[3] = rr(OP_OR, 20, 20, 20);
    dut.Mem[4] = rr(OP_MUL, 2, 2, 3);
    dut.Mem[5] = ri(OP_SUBI, 3, 3, 1);
    dut.Mem[6] = ri(OP_BNEQZ, 0, 3, -3);
    dut.Mem[7] = ri(OP_SW, 2, 10, -2);
    dut.Mem[8] = hlt_w;
    run("fact", 1000);
    check("fact_mem198", dut.Mem[198], 32'd5040);
    check("fact_r3", dut.Reg[3], 32'd0);
    check("fact_taken", taken_cnt, 32'd6);

    // Branch flush
    prep();
    dut.Mem[0] = ri(OP_BEQZ, 0, 0, 2);
    dut.Mem[1] = ri(OP_ADDI, 9, 0, 1);
    dut.Mem[2] = ri(OP_ADDI, 9, 0, 1);
    dut.Mem[3] = hlt_w;
    run("flush", 200);
    check("flush_r9", dut.Reg[9], 32'd9);
    check("flush_taken", taken_cnt, 32'd1);

    // Taken branch beats a younger HLT; a not-taken branch goes first
    prep();
    dut.Mem[0] = ri(OP_BNEQZ, 0, 0, 5);
    dut.Mem[1] = ri(OP_BEQZ, 0, 0, 2);
    dut.Mem[2] = hlt_w;
    dut.Mem[3] = ri(OP_ADDI, 9, 0, 1);
    dut.Mem[4] = ri(OP_ADDI, 12, 0, 44);
    dut.Mem[5] = hlt_w;
    run("ovr", 200);
    check("ovr_r9", dut.Reg[9], 32'd9);
    check("ovr_r12", dut.Reg[12], 32'd44);
    check("ovr_taken", taken_cnt, 32'd1);
    check("ovr_pc", dut.PC, 32'd6);

    // Halt blocks the following store
    prep();
    dut.Mem[0] = ri(OP_ADDI, 1, 0, 7);
    dut.Mem[1] = hlt_w;
    dut.Mem[2] = ri(OP_SW, 1, 0, 300);
    run("hlt", 200);
    repeat (20) @(negedge clk1);
    check("hlt_mem300", dut.Mem[300], 32'd0);
    check("hlt_pc", dut.PC, 32'd2);
    check("hlt_sticky", {31'd0, halted}, 32'd1);
    check("hlt_r1", dut.Reg[1], 32'd7);

    // Asynchronous reset away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("areset_pc", dut.PC, 32'd0);
    check("areset_halted", {31'd0, halted}, 32'd0);
    check("areset_r1", dut.Reg[1], 32'd7);
    check("areset_mem0", dut.Mem[0], ri(OP_ADDI, 1, 0, 7));
    check("areset_mem1", dut.Mem[1], hlt_w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
